// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM state encoding, frame magic byte
// and word-count width.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_CSUM   = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } boot_state_t;

    localparam logic [7:0] BOOT_MAGIC = 8'hA5;
    localparam int         CNT_W      = 16;

    // States in which the loader is willing to take a byte from the source.
    function automatic logic state_accepts(input boot_state_t s);
        return (s == S_IDLE) || (s == S_LEN_HI) || (s == S_LEN_LO) ||
               (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/boot_loader_word_asm.sv
// Big-endian word assembler: shifts payload bytes into a 32-bit word, counts
// bytes within the word and keeps the running XOR of every payload byte.
module boot_word_asm
    import boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full,
    output logic [7:0]  csum
);

    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  csum_q, csum_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        csum_d = csum_q;
        if (clr) begin
            word_d = '0;
            cnt_d  = '0;
            csum_d = '0;
        end else if (byte_valid) begin
            word_d = {word_q[23:0], byte_in};
            cnt_d  = cnt_q + 2'd1;
            csum_d = csum_q ^ byte_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            word_q <= '0;
            cnt_q  <= '0;
            csum_q <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
            csum_q <= csum_d;
        end
    end

    // Asserted while the fourth byte of a word is being accepted.
    assign word_full = byte_valid && (cnt_q == 2'd3);
    assign word      = word_q;
    assign csum      = csum_q;

endmodule

// File: rtl/boot_loader.sv
// Framed byte-stream loader: writes a checksummed program image into
// instruction memory and holds the core in reset until the image is verified.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    boot_state_t      state_q, state_d;
    logic             rx_ready_q, rx_ready_d;
    logic             imem_we_q, imem_we_d;
    logic [31:0]      imem_addr_q, imem_addr_d;
    logic             cpu_hold_q, cpu_hold_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [7:0]       len_hi_q, len_hi_d;
    logic [CNT_W-1:0] words_left_q, words_left_d;

    logic             accept;
    logic             asm_clr;
    logic             asm_valid;
    logic             word_full;
    logic [7:0]       run_csum;
    logic [CNT_W-1:0] count_w;

    // A byte transfers only when both sides agree in the same cycle:
    // rx_valid && rx_ready. The source must hold the byte otherwise.
    assign accept    = rx_valid && rx_ready_q;
    assign asm_valid = accept && (state_q == S_DATA);
    assign count_w   = {len_hi_q, rx_data};

    boot_word_asm u_word_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (asm_clr),
        .byte_valid (asm_valid),
        .byte_in    (rx_data),
        .word       (imem_wdata),
        .word_full  (word_full),
        .csum       (run_csum)
    );

    always_comb begin
        state_d      = state_q;
        len_hi_d     = len_hi_q;
        words_left_d = words_left_q;
        imem_addr_d  = imem_addr_q;
        asm_clr      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && (rx_data == BOOT_MAGIC)) begin
                    state_d = S_LEN_HI;
                    asm_clr = 1'b1;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_hi_d = rx_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    words_left_d = count_w;
                    if (32'(count_w) > MAX_WORDS) begin
                        state_d = S_ERR;
                    end else if (count_w == '0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (word_full) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                imem_addr_d  = imem_addr_q + 32'd4;
                words_left_d = words_left_q - 16'd1;
                state_d      = (words_left_q == 16'd1) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (accept) begin
                    state_d = (rx_data == run_csum) ? S_DONE : S_ERR;
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase

        // Outputs are registered from the next state so they line up with it.
        rx_ready_d = state_accepts(state_d);
        imem_we_d  = (state_d == S_WRITE);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
        cpu_hold_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_ADDR;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            len_hi_q     <= '0;
            words_left_q <= '0;
        end else begin
            state_q      <= state_d;
            rx_ready_q   <= rx_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            err_q        <= err_d;
            len_hi_q     <= len_hi_d;
            words_left_q <= words_left_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign imem_we   = imem_we_q;
    assign imem_addr = imem_addr_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: frames are driven byte by byte and every
// instruction-memory write is matched against an expected queue.
module tb_boot_loader;

    logic        clk;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    boot_loader #(
        .BASE_ADDR (32'h0000_0000),
        .MAX_WORDS (1024)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reset held for three cycles with a magic byte offered; nothing may move.
    task automatic do_reset();
        rst      = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("rst_rx_ready", 64'(rx_ready), 64'd0);
                check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
                check("rst_imem_we", 64'(imem_we), 64'd0);
                check("rst_imem_addr", 64'(imem_addr), 64'd0);
                check("rst_done_err", 64'({done, err}), 64'd0);
            end
        end
        @(posedge clk);
        #1;
        rst      = 1'b1;
        rx_valid = 1'b0;
    endtask

    // Driver: offer one byte and hold it until the loader takes it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        while (!rx_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check("hs_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every write strobe must match the head of exp_q.
    always @(negedge clk) begin
        if (rst && imem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {imem_addr, imem_wdata}, 64'd0);
            end else begin
                check("imem_write", {imem_addr, imem_wdata}, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] frame[11];
        frame = '{8'hA5, 8'h00, 8'h02, 8'h34, 8'h01, 8'h00, 8'h05,
                  8'h00, 8'h00, 8'h00, 8'h08};
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // Two-word load with write-latency check
        do_reset();
        exp_q.push_back({32'h0, 32'h3401_0005});
        exp_q.push_back({32'h4, 32'h0000_0008});
        for (int i = 0; i < 11; i++) begin
            send_byte(frame[i]);
            if (i == 6) begin
                @(negedge clk);
                check("we_latency", 64'(imem_we), 64'd1);
            end
        end
        @(negedge clk);
        check("pre_csum_done", 64'(done), 64'd0);
        send_byte(8'h38);
        @(negedge clk);
        check("load_done", 64'(done), 64'd1);
        check("load_cpu_hold", 64'(cpu_hold), 64'd0);
        check("load_err", 64'(err), 64'd0);
        check("load_rx_ready", 64'(rx_ready), 64'd0);
        check("load_final_addr", 64'(imem_addr), 64'h8);
        check("load_writes_left", 64'(exp_q.size()), 64'd0);

        // Bad checksum: error is sticky and the input is ignored
        do_reset();
        exp_q.push_back({32'h0, 32'h3401_0005});
        exp_q.push_back({32'h4, 32'h0000_0008});
        for (int i = 0; i < 11; i++) send_byte(frame[i]);
        send_byte(8'h39);
        @(negedge clk);
        check("bad_err", 64'(err), 64'd1);
        check("bad_done", 64'(done), 64'd0);
        check("bad_cpu_hold", 64'(cpu_hold), 64'd1);
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bad_rx_ready", 64'(rx_ready), 64'd0);
        end
        rx_valid = 1'b0;
        check("bad_err_sticky", 64'(err), 64'd1);
        check("bad_writes_left", 64'(exp_q.size()), 64'd0);

        // Garbage before the magic byte and gaps inside the payload
        do_reset();
        exp_q.push_back({32'h0, 32'h3401_0005});
        exp_q.push_back({32'h4, 32'h0000_0008});
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        for (int i = 0; i < 11; i++) begin
            send_byte(frame[i]);
            if (i == 4 || i == 8) idle(5);
        end
        send_byte(8'h38);
        @(negedge clk);
        check("gap_done", 64'(done), 64'd1);
        check("gap_cpu_hold", 64'(cpu_hold), 64'd0);
        check("gap_writes_left", 64'(exp_q.size()), 64'd0);

        // Zero-length image: done with no write
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        @(negedge clk);
        check("zero_done", 64'(done), 64'd1);
        check("zero_addr", 64'(imem_addr), 64'h0);

        // Oversized count: error right after the count byte
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h01);
        @(negedge clk);
        check("over_err", 64'(err), 64'd1);
        check("over_rx_ready", 64'(rx_ready), 64'd0);
        check("over_done", 64'(done), 64'd0);

        // Reset mid-load, then a complete one-word frame
        do_reset();
        exp_q.push_back({32'h0, 32'h3401_0005});
        for (int i = 0; i < 9; i++) send_byte(frame[i]);
        do_reset();
        check("midrst_addr", 64'(imem_addr), 64'h0);
        exp_q.push_back({32'h0, 32'hDEAD_BEEF});
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        send_byte(8'h22);
        @(negedge clk);
        check("midrst_done", 64'(done), 64'd1);
        check("midrst_addr_after", 64'(imem_addr), 64'h4);
        check("midrst_writes_left", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Byte-stream program loader sitting directly upstream of the instruction memory.
- Receives a framed image from a byte source (UART receiver or testbench), assembles big-endian 32-bit words and writes them sequentially into instruction memory.
- Holds the MIPS core in reset until a complete, checksum-verified image has been written; then releases the core.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction word written
- MAX_WORDS, 1024, largest accepted word count; must match instruction memory depth

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- rx_valid  in  1  byte source has a byte on rx_data
- rx_data  in  8  incoming byte
- rx_ready  out  1  loader accepts a byte this cycle; a byte transfers when rx_valid && rx_ready
- imem_we  out  1  one-cycle instruction memory write strobe
- imem_addr  out  32  word-aligned byte address for the write
- imem_wdata  out  32  assembled instruction word
- cpu_hold  out  1  1 = keep core in reset; top level maps this to the core reset polarity
- done  out  1  image loaded and verified
- err  out  1  frame rejected (sticky)

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst==0 at a clk edge): state=IDLE, rx_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_hold=1, done=0, err=0. Counters and checksum are cleared. Reset mid-load abandons the frame; already written words are not erased.
- rx_ready=1 in IDLE, LEN_HI, LEN_LO, DATA and CSUM; it is 0 in WRITE, DONE and ERR.
- Frame format: 0xA5 magic, count[15:8], count[7:0], then count words of 4 bytes each (MSB first), then 1 checksum byte. The checksum is the XOR of every payload byte (not magic or count).
- IDLE: a byte other than 0xA5 is discarded and the state stays IDLE. 0xA5 -> LEN_HI.
- LEN_HI -> LEN_LO.
- LEN_LO: the 16-bit count is latched.
  - count > MAX_WORDS -> ERR.
  - count == 0 -> CSUM.
  - otherwise -> DATA.
- DATA: each accepted byte shifts into wdata ({wdata[23:0],byte}) and is XORed into the checksum. On the 4th byte -> WRITE.
- WRITE, one cycle, no byte accepted:
  - imem_we=1 with the current imem_addr/imem_wdata.
  - On the next cycle imem_addr += 4 and words_left -= 1.
  - words_left == 0 -> CSUM, else -> DATA.
- imem_we is high only in WRITE. Latency is 1 cycle from the 4th-byte handshake edge to the strobe.
- CSUM: a received byte equal to the running XOR -> DONE; otherwise -> ERR.
- DONE: done=1 and cpu_hold=0 from the cycle after the checksum handshake. Terminal until reset.
- ERR: err=1, cpu_hold stays 1, all input is ignored. Terminal until reset.
- rx_valid without rx_ready: the byte is not consumed; the source must hold it.
- imem_addr wraps modulo 2^32. MAX_WORDS prevents wrap in legal use.
- Outputs are registered; there are no combinational paths from rx_* to outputs except rx_ready, which is state-only.

Decomposition:
- Shared package/header (def.v style):
  - state encodings IDLE..ERR (3 bits)
  - BOOT_MAGIC 8'hA5
  - word-count width 16
- Sub-module boot_word_asm: 4-byte shift register with byte counter, "word_full" flag and running XOR. The FSM stays in boot_loader.
- SoC integration:
  - InstMem is replaced by a writable instruction RAM with a write port (we/addr/wdata).
  - cpu_hold is ORed into the core reset.

Test Plan:
- Reset hold: rst=0 for 3 cycles with rx_valid=1, rx_data=8'hA5 -> rx_ready=0, cpu_hold=1, imem_we=0, imem_addr=0 throughout.
- Two-word load: stream A5 00 02 34 01 00 05 00 00 00 08 with checksum 0x34^01^00^05^00^00^00^08=0x38, then 38:
  - imem_we pulses at addr 0x0 data 0x34010005, then at addr 0x4 data 0x00000008
  - done=1 and cpu_hold=0 the cycle after the checksum
- Bad checksum: same frame ending with 0x39 -> err=1, done=0, cpu_hold stays 1; later bytes are ignored with rx_ready=0.
- Garbage and gaps: 00 FF 12 before A5, plus rx_valid low for 5 cycles between payload bytes -> garbage discarded and the load completes identically to the two-word case.
- Limits:
  - count=0 (A5 00 00 00) -> done with no imem_we.
  - count=MAX_WORDS+1 (A5 04 01) -> err immediately after the count byte.
- Reset mid-load: assert rst after 6 payload bytes, then send a full one-word frame -> single write at BASE_ADDR and done=1.
